rvb_bitcnt_core: RTL and testbench
==================================

Name: rvb_bitcnt_core

Overview:
- Single-stage pipelined bit-count execution unit for the RISC-V bitmanip ALU.
- Computes clz, ctz and pcnt on rs1, plus the W variants on RV64.
- Optionally computes bmatflip (8x8 bit-matrix transpose) on RV64.
- Sits behind the decode stage with a valid/ready handshake on both input and output.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- BMAT, 0, when 1 (and XLEN=64 and the macro is defined), enables bmatflip.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din_valid  in  1  input operation valid.
- din_ready  out  1  unit can accept an input this cycle.
- din_rs1  in  XLEN  source operand.
- din_insn3  in  1  instruction bit 3: W variant select. Ignored when XLEN=32.
- din_insn20  in  1  instruction bit 20: op select, low bit.
- din_insn21  in  1  instruction bit 21: op select, high bit.
- dout_valid  out  1  result valid.
- dout_ready  in  1  consumer accepts the result.
- dout_rd  out  XLEN  result.

Behaviour:
- Op select {insn21,insn20}:
  - 00 clz: count of leading zeros.
  - 01 ctz: count of trailing zeros.
  - 10 pcnt: population count.
  - 11 bmatflip.
- Operand width:
  - Full-width ops operate on all XLEN bits.
  - W variant (XLEN=64, insn3=1) operates on rs1[31:0] only.
- Zero input: clz(0) and ctz(0) return the operand width (XLEN, or 32 for W).
- Result encoding: counts are zero-extended to XLEN. Counts are never negative, so this matches sign-extension.
- bmatflip:
  - Treats rs1 as 8 bytes; byte i is row i, bit j of a byte is column j.
  - Output bit (8*j+i) = input bit (8*i+j).
  - insn3 is ignored for bmatflip.
- Op 11 when bmatflip is not enabled (BMAT=0, XLEN=32, or macro undefined): dout_rd = 0.
- Handshake:
  - din_ready = !dout_valid || dout_ready (combinational).
  - An input is accepted when din_valid && din_ready.
  - On accept, the result is registered into dout_rd and dout_valid=1 on the next edge. Latency is 1 cycle.
- Output hold: when dout_valid && !dout_ready, dout_rd and dout_valid hold stable and din_ready=0.
- Release: when dout_valid && dout_ready with no new accept, dout_valid clears on the next edge.
- Simultaneous output pop and input accept: the new result replaces the old one; dout_valid stays 1. Full throughput is one op per cycle.
- Reset:
  - dout_valid=0 and dout_rd=0.
  - Reset takes priority over any handshake in the same cycle.
  - Mid-operation reset discards a pending result.
- Inputs are sampled only on accept; other input values are don't-care.

Optional Feature:
- Macro RVB_BITCNT_BMAT_EN.
- Defined: the bmatflip transpose network is compiled in and active when BMAT=1 and XLEN=64.
- Undefined: no transpose logic is generated; op 11 always returns 0 regardless of BMAT.

Decomposition:
- Shared package rvb_pkg holds:
  - op-code localparams OP_CLZ=2'b00, OP_CTZ=2'b01, OP_PCNT=2'b10, OP_BMATFLIP=2'b11;
  - legal XLEN constants.
- One natural sub-module: rvb_bitcnt_count, combinational.
  - Inputs: XLEN-wide operand, op, W flag.
  - Output: count.
  - Implementation: bit-reverse the operand for clz, isolate the lowest set bit via (x & -x), mask to 32 bits for W, then popcount.
- The top level holds the handshake register and the bmatflip mux.

Test Plan:
- XLEN=32, clz, rs1=0x00010000 -> rd=15; rs1=0 -> rd=32.
- XLEN=32, ctz, rs1=0x00000080 -> rd=7; pcnt, rs1=0xF0F0000F -> rd=12.
- XLEN=64:
  - clzw, rs1=0xFFFFFFFF00000001 -> rd=31.
  - pcntw, same rs1 -> rd=1.
  - ctz, rs1=0 -> rd=64.
- XLEN=64, BMAT=1, macro defined:
  - bmatflip, rs1=0x00000000000000FF -> rd=0x0101010101010101.
  - Same op without the macro -> rd=0.
- Backpressure: hold dout_ready=0 for 3 cycles after a result.
  - Required: din_ready=0 and dout_rd stable.
  - On release, the next input is accepted in the same cycle as the pop.
- Randomized stream: 1000 ops with random din_valid/dout_ready. Every result matches the reference model in order, with no drops or duplicates. Assert reset mid-stream: dout_valid=0 on the next cycle.

Source files
------------

// File: rtl/rvb_pkg.sv
// Shared bitmanip ALU constants: op-codes and legal datapath widths.
// Imported by the bit-count unit and its counting network.
package rvb_pkg;

  localparam int XLEN32 = 32;
  localparam int XLEN64 = 64;

  localparam logic [1:0] OP_CLZ      = 2'b00;
  localparam logic [1:0] OP_CTZ      = 2'b01;
  localparam logic [1:0] OP_PCNT     = 2'b10;
  localparam logic [1:0] OP_BMATFLIP = 2'b11;

endpackage

// File: rtl/rvb_bitcnt_count.sv
// Combinational clz/ctz/pcnt network, all three folded onto one popcount.
// W selects the low-word variant (operand masked to rs1[31:0]).
module rvb_bitcnt_count
  import rvb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [1:0]      op,
  input  logic            w,
  output logic [XLEN-1:0] cnt
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] W_MASK = XLEN'({32{1'b1}});

  logic [XLEN-1:0] rev;
  logic [XLEN-1:0] wm;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] lsb;
  logic [XLEN-1:0] msk;
  logic [XLEN-1:0] pop_in;
  logic [CW-1:0]   sum;

  always_comb begin
    rev = '0;
    if (w) begin
      for (int i = 0; i < 32; i++) begin
        rev[i] = rs1[31-i];
      end
    end else begin
      for (int i = 0; i < XLEN; i++) begin
        rev[i] = rs1[XLEN-1-i];
      end
    end
  end

  // Trailing zeros = ones in (lsb - 1); zero input wraps to all-ones,
  // which the width mask trims to exactly the operand width.
  always_comb begin
    wm     = w ? W_MASK : '1;
    src    = ((op == OP_CLZ) ? rev : rs1) & wm;
    lsb    = src & (~src + XLEN'(1));
    msk    = (lsb - XLEN'(1)) & wm;
    pop_in = (op == OP_PCNT) ? src : msk;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < XLEN; i++) begin
      sum = sum + CW'(pop_in[i]);
    end
  end

  assign cnt = XLEN'(sum);

endmodule

// File: rtl/rvb_bitcnt_core.sv
// Single-stage bit-count unit with valid/ready on both sides.
// bmatflip is compiled in only with RVB_BITCNT_BMAT_EN defined.
module rvb_bitcnt_core
  import rvb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BMAT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic            din_insn3,
  input  logic            din_insn20,
  input  logic            din_insn21,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rd
);

  logic [1:0]      op;
  logic            w;
  logic            accept;
  logic [XLEN-1:0] cnt;
  logic [XLEN-1:0] flip;
  logic [XLEN-1:0] res;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] rd_d, rd_q;

  assign op = {din_insn21, din_insn20};
  assign w  = (XLEN == XLEN64) && din_insn3;

  rvb_bitcnt_count #(
    .XLEN(XLEN)
  ) u_count (
    .rs1(din_rs1),
    .op (op),
    .w  (w),
    .cnt(cnt)
  );

`ifdef RVB_BITCNT_BMAT_EN
  if (BMAT == 1 && XLEN == XLEN64) begin : g_bmat
    always_comb begin
      flip = '0;
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          flip[8*j+i] = din_rs1[8*i+j];
        end
      end
    end
  end else begin : g_no_bmat
    assign flip = '0;
  end
`else
  assign flip = '0;
`endif

  assign res = (op == OP_BMATFLIP) ? flip : cnt;

  assign din_ready = !valid_q || dout_ready;
  assign accept    = din_valid && din_ready;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    if (accept) begin
      valid_d = 1'b1;
      rd_d    = res;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  assign dout_valid = valid_q;
  assign dout_rd    = rd_q;

endmodule

// File: tb/tb_rvb_bitcnt_core.sv
// Directed and random-stream bench for rvb_bitcnt_core (32 and 64 bit).
// bmatflip expectations follow RVB_BITCNT_BMAT_EN.
module tb_rvb_bitcnt_core;

  logic clock = 1'b0;
  logic reset;

  logic        v32, r32, i3_32, i20_32, i21_32, ov32, ordy32;
  logic [31:0] rs32, rd32;
  logic        v64, r64, i3_64, i20_64, i21_64, ov64, ordy64;
  logic [63:0] rs64, rd64;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  rvb_bitcnt_core #(
    .XLEN(32),
    .BMAT(0)
  ) u32 (
    .clock     (clock),
    .reset     (reset),
    .din_valid (v32),
    .din_ready (r32),
    .din_rs1   (rs32),
    .din_insn3 (i3_32),
    .din_insn20(i20_32),
    .din_insn21(i21_32),
    .dout_valid(ov32),
    .dout_ready(ordy32),
    .dout_rd   (rd32)
  );

  rvb_bitcnt_core #(
    .XLEN(64),
    .BMAT(1)
  ) u64 (
    .clock     (clock),
    .reset     (reset),
    .din_valid (v64),
    .din_ready (r64),
    .din_rs1   (rs64),
    .din_insn3 (i3_64),
    .din_insn20(i20_64),
    .din_insn21(i21_64),
    .dout_valid(ov64),
    .dout_ready(ordy64),
    .dout_rd   (rd64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] bmat_ref(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
`ifdef RVB_BITCNT_BMAT_EN
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r[8*j+i] = x[8*i+j];
`endif
    return r;
  endfunction

  function automatic logic [63:0] ref64(input logic [1:0] op,
                                        input logic w,
                                        input logic [63:0] x);
    int n;
    int c;
    bit done;
    n = w ? 32 : 64;
    c = 0;
    done = 0;
    if (op == 2'b11) return bmat_ref(x);
    if (op == 2'b00) begin
      for (int i = n - 1; i >= 0; i--)
        if (!done) begin
          if (x[i]) done = 1;
          else c++;
        end
    end else if (op == 2'b01) begin
      for (int i = 0; i < n; i++)
        if (!done) begin
          if (x[i]) done = 1;
          else c++;
        end
    end else begin
      for (int i = 0; i < n; i++) c += int'(x[i]);
    end
    return 64'(c);
  endfunction

  task automatic op32(input logic [1:0] op, input logic i3,
                      input logic [31:0] x, output logic [31:0] rd);
    @(negedge clock);
    v32 = 1'b1; rs32 = x; {i21_32, i20_32} = op;
    i3_32 = i3; ordy32 = 1'b1;
    @(posedge clock);
    #1;
    v32 = 1'b0;
    chk("v32", 64'(ov32), 64'd1);
    rd = rd32;
  endtask

  task automatic op64(input logic [1:0] op, input logic i3,
                      input logic [63:0] x, output logic [63:0] rd);
    @(negedge clock);
    v64 = 1'b1; rs64 = x; {i21_64, i20_64} = op;
    i3_64 = i3; ordy64 = 1'b1;
    @(posedge clock);
    #1;
    v64 = 1'b0;
    chk("v64", 64'(ov64), 64'd1);
    rd = rd64;
  endtask

  logic [31:0] r_32;
  logic [63:0] r_64;
  logic [63:0] q[$];
  int acc;
  int cyc;
  int n;

  initial begin
    reset = 1'b1;
    v32 = 0; rs32 = '0; i3_32 = 0; i20_32 = 0; i21_32 = 0; ordy32 = 0;
    v64 = 0; rs64 = '0; i3_64 = 0; i20_64 = 0; i21_64 = 0; ordy64 = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_v32", 64'(ov32), 64'd0);
    chk("rst_rd32", 64'(rd32), 64'd0);
    chk("rst_v64", 64'(ov64), 64'd0);
    chk("rst_rd64", rd64, 64'd0);
    chk("rst_rdy32", 64'(r32), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    op32(2'b00, 0, 32'h0001_0000, r_32); chk("clz32", 64'(r_32), 64'd15);
    op32(2'b00, 1, 32'h0001_0000, r_32); chk("clz32_i3", 64'(r_32), 64'd15);
    op32(2'b00, 0, 32'h0, r_32);         chk("clz32_0", 64'(r_32), 64'd32);
    op32(2'b01, 0, 32'h0000_0080, r_32); chk("ctz32", 64'(r_32), 64'd7);
    op32(2'b01, 0, 32'h0, r_32);         chk("ctz32_0", 64'(r_32), 64'd32);
    op32(2'b10, 0, 32'hF0F0_000F, r_32); chk("pcnt32", 64'(r_32), 64'd12);
    op32(2'b11, 0, 32'h0000_00FF, r_32); chk("bmat32", 64'(r_32), 64'd0);

    op64(2'b00, 1, 64'hFFFF_FFFF_0000_0001, r_64); chk("clzw", r_64, 64'd31);
    op64(2'b10, 1, 64'hFFFF_FFFF_0000_0001, r_64); chk("pcntw", r_64, 64'd1);
    op64(2'b10, 0, 64'hFFFF_FFFF_0000_0001, r_64); chk("pcnt64", r_64, 64'd33);
    op64(2'b01, 0, 64'h0, r_64);                   chk("ctz64_0", r_64, 64'd64);
    op64(2'b01, 1, 64'hFFFF_FFFF_0000_0000, r_64); chk("ctzw_0", r_64, 64'd32);
    op64(2'b00, 0, 64'h0000_0001_0000_0000, r_64); chk("clz64", r_64, 64'd31);
    op64(2'b00, 0, 64'hFFFF_FFFF_FFFF_FFFF, r_64); chk("clz64_1s", r_64, 64'd0);
    op64(2'b00, 1, 64'h0, r_64);                   chk("clzw_0", r_64, 64'd32);
`ifdef RVB_BITCNT_BMAT_EN
    op64(2'b11, 0, 64'hFF, r_64); chk("bmat", r_64, 64'h0101_0101_0101_0101);
    op64(2'b11, 1, 64'hFF, r_64); chk("bmat_w", r_64, 64'h0101_0101_0101_0101);
`else
    op64(2'b11, 0, 64'hFF, r_64); chk("bmat_off", r_64, 64'd0);
`endif

    // backpressure on the 32-bit unit
    @(negedge clock);
    v32 = 1; rs32 = 32'h0001_0000; {i21_32, i20_32} = 2'b00; ordy32 = 0;
    @(posedge clock);
    #1;
    chk("bp_v", 64'(ov32), 64'd1);
    chk("bp_rd", 64'(rd32), 64'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      rs32 = 32'h80; {i21_32, i20_32} = 2'b01;
      #1;
      chk("bp_rdy", 64'(r32), 64'd0);
      @(posedge clock);
      #1;
      chk("bp_hold_v", 64'(ov32), 64'd1);
      chk("bp_hold_rd", 64'(rd32), 64'd15);
    end
    @(negedge clock);
    ordy32 = 1;
    #1;
    chk("bp_rel_rdy", 64'(r32), 64'd1);
    @(posedge clock);
    #1;
    v32 = 0;
    chk("bp_new_v", 64'(ov32), 64'd1);
    chk("bp_new_rd", 64'(rd32), 64'd7);
    @(posedge clock);
    #1;
    chk("bp_drain_v", 64'(ov32), 64'd0);

    // random stream on the 64-bit unit
    acc = 0;
    cyc = 0;
    while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clock);
      v64 = (acc < 1000) && ($urandom_range(0, 3) != 0);
      rs64 = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rs64 = '0;
      if ($urandom_range(0, 7) == 0) rs64 = rs64 >> $urandom_range(0, 63);
      {i21_64, i20_64} = 2'($urandom_range(0, 3));
      i3_64 = 1'($urandom_range(0, 1));
      ordy64 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov64 && ordy64) begin
        n = q.size();
        chk("stream_q", 64'(n != 0), 64'd1);
        if (n != 0) chk("stream", rd64, q.pop_front());
      end
      if (v64 && r64) begin
        q.push_back(ref64({i21_64, i20_64}, i3_64, rs64));
        acc++;
      end
      cyc++;
    end
    chk("stream_acc", 64'(acc), 64'd1000);
    chk("stream_left", 64'(q.size()), 64'd0);

    // reset with a result pending
    @(negedge clock);
    v64 = 1; rs64 = 64'h5; {i21_64, i20_64} = 2'b10; i3_64 = 0; ordy64 = 0;
    @(posedge clock);
    #1;
    chk("mr_pend", 64'(ov64), 64'd1);
    chk("mr_rd", rd64, 64'd2);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;
    chk("mr_v", 64'(ov64), 64'd0);
    chk("mr_rd0", rd64, 64'd0);
    @(negedge clock);
    reset = 0;
    v64 = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
